// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/redirect controller for the 5-stage pipeline.
// It detects load-use hazards and multi-cycle mul/div occupancy, and gates the
// branch and jump redirects that ID resolves.
// Latency: all hazard and redirect outputs are combinational from the ID/EX
// fields in the same cycle. MdBusy is registered (FSM state).
// Backpressure: Stall freezes PC and IF/ID. The ID instruction is held, so any
// suppressed redirect reasserts on the first non-stalled cycle.
// Ports: Clk/Reset_n (async active-low); ID operand fields IdRs/IdRt with use
// flags; EX load info ExMemRead/ExRt; IdMulDiv/IdBranchTaken/IdJump from ID.
// Outputs: Stall, Branch, Jump, ExBubble and MdBusy.
// Optional: define HAZARD_PERF_CNT_EN to add 32-bit saturating counters
// StallCycles, LoadUseEvents and RedirectCount.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [4:0] IdRs,
  input  logic [4:0] IdRt,
  input  logic       IdUsesRs,
  input  logic       IdUsesRt,
  input  logic       ExMemRead,
  input  logic [4:0] ExRt,
  input  logic       IdMulDiv,
  input  logic       IdBranchTaken,
  input  logic       IdJump,
  output logic       Stall,
  output logic       Branch,
  output logic       Jump,
  output logic       ExBubble,
  output logic       MdBusy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] LoadUseEvents,
  output logic [31:0] RedirectCount
`endif
);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic load_use;
  logic md_hazard;
  logic stall_int;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign load_use = ExMemRead && (ExRt != 5'd0) &&
                    ((IdUsesRs && (IdRs == ExRt)) || (IdUsesRt && (IdRt == ExRt)));

  // While the unit is busy, anything reading a register or issuing another
  // mul/div waits. Register-free instructions slip through.
  assign md_hazard = (state_q == MD_WAIT) && (IdMulDiv || IdUsesRs || IdUsesRt);

  // Outputs are forced low while reset is held, regardless of the inputs.
  assign stall_int = Reset_n && (load_use || md_hazard);
  assign Stall     = stall_int;
  assign ExBubble  = stall_int;
  assign Branch    = Reset_n && IdBranchTaken && !stall_int;
  // Branch takes priority when both redirects are asserted.
  assign Jump      = Reset_n && IdJump && !stall_int && !IdBranchTaken;
  assign MdBusy    = (state_q == MD_WAIT);

  // Counter is loaded with MULDIV_CYCLES-1 on issue and the FSM leaves MD_WAIT
  // on the edge where it reads 1, giving MULDIV_CYCLES-1 busy cycles. The
  // counter is held at 0 in RUN.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (IdMulDiv && !stall_int) begin
            state_q <= MD_WAIT;
            cnt_q   <= MD_LOAD;
          end else begin
            cnt_q   <= '0;
          end
        end
        MD_WAIT: begin
          if (cnt_q <= CNT_ONE) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic        load_use_q;
  logic [31:0] stall_cycles_q;
  logic [31:0] load_use_events_q;
  logic [31:0] redirect_count_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      load_use_q        <= 1'b0;
      stall_cycles_q    <= '0;
      load_use_events_q <= '0;
      redirect_count_q  <= '0;
    end else begin
      load_use_q <= load_use;
      if (stall_int)
        stall_cycles_q <= sat_inc(stall_cycles_q);
      // Count rising edges of the load-use hazard only.
      if (load_use && !load_use_q)
        load_use_events_q <= sat_inc(load_use_events_q);
      if (Branch || Jump)
        redirect_count_q <= sat_inc(redirect_count_q);
    end
  end

  assign StallCycles   = stall_cycles_q;
  assign LoadUseEvents = load_use_events_q;
  assign RedirectCount = redirect_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       Clk;
  logic       Reset_n;
  logic [4:0] IdRs, IdRt, ExRt;
  logic       IdUsesRs, IdUsesRt, ExMemRead, IdMulDiv, IdBranchTaken, IdJump;
  logic       Stall, Branch, Jump, ExBubble, MdBusy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCycles, LoadUseEvents, RedirectCount;
`endif

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.MULDIV_CYCLES(8), .CNT_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .IdRs(IdRs), .IdRt(IdRt), .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt),
    .ExMemRead(ExMemRead), .ExRt(ExRt), .IdMulDiv(IdMulDiv),
    .IdBranchTaken(IdBranchTaken), .IdJump(IdJump),
    .Stall(Stall), .Branch(Branch), .Jump(Jump), .ExBubble(ExBubble), .MdBusy(MdBusy)
`ifdef HAZARD_PERF_CNT_EN
    , .StallCycles(StallCycles), .LoadUseEvents(LoadUseEvents), .RedirectCount(RedirectCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs and expected outputs {Stall,Branch,Jump,ExBubble,MdBusy}.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic       muldiv;
    logic       br;
    logic       jmp;
    logic [4:0] exp;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {Stall, Branch, Jump, ExBubble, MdBusy};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {Stall,Branch,Jump,ExBubble,MdBusy}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic mr, input logic [4:0] ert,
                        input logic md, input logic br, input logic jmp);
    IdRs = rs; IdRt = rt; IdUsesRs = urs; IdUsesRt = urt; ExMemRead = mr;
    ExRt = ert; IdMulDiv = md; IdBranchTaken = br; IdJump = jmp;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    //            rs     rt     urs  urt  mr   ert    md   br   jmp  exp
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'b10010};
    vecs[2]  = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[3]  = '{5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'b10010};
    vecs[4]  = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[5]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b01000};
    vecs[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'b00100};
    vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b01000};
    vecs[9]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 5'b10010};
    vecs[10] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 5'b01000};
    vecs[11] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 5'b10010};
    vecs[12] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'b10010};
    vecs[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[14] = '{5'd5, 5'd6, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'b00000};

    // Reset held with every input high: all outputs low.
    Reset_n = 1'b0;
    set_in(5'h1F, 5'h1F, 1'b1, 1'b1, 1'b1, 5'h1F, 1'b1, 1'b1, 1'b1);
    #3;
    check("reset_all_high", 5'b00000);
    tick();
    tick();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    #3;
    check("reset_release_run", 5'b00000);
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if ({StallCycles, LoadUseEvents, RedirectCount} !== 96'd0) begin
      bad++;
      $display("FAIL perf_after_reset: got %h %h %h expected 0", StallCycles, LoadUseEvents, RedirectCount);
    end
`endif
    tick();

    // Single-cycle combinational vectors, one clock each, all in RUN.
    for (int i = 0; i < NV; i++) begin
      set_in(vecs[i].rs, vecs[i].rt, vecs[i].uses_rs, vecs[i].uses_rt, vecs[i].mem_read,
             vecs[i].ex_rt, vecs[i].muldiv, vecs[i].br, vecs[i].jmp);
      #3;
      check($sformatf("vec%0d", i), vecs[i].exp);
      tick();
    end

    // Mul/div issue, then a dependent instruction stalls for 7 cycles.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    #3;
    check("md_issue", 5'b00000);
    tick();
    set_in(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      #3;
      check($sformatf("md_dep_c%0d", c), 5'b10011);
      tick();
    end
    #3;
    check("md_dep_done", 5'b00000);
    tick();

    // Register-free instruction proceeds while the unit is busy; a branch
    // issued alongside it is not blocked.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 7; c++) begin
      #3;
      check($sformatf("md_free_c%0d", c), 5'b01001);
      tick();
    end
    #3;
    check("md_free_done", 5'b01000);
    tick();

    // A new mul/div held in ID stalls through MD_WAIT, issues the cycle after,
    // and starts a fresh busy window with no overlap.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 7; c++) begin
      #3;
      check($sformatf("md_b2b_c%0d", c), 5'b10011);
      tick();
    end
    #3;
    check("md_b2b_issue_run", 5'b00000);
    tick();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #3;
    check("md_b2b_busy_again", 5'b00001);
    for (int c = 0; c < 7; c++) tick();
    #3;
    check("md_b2b_drained", 5'b00000);
    tick();

    // Reset in the 3rd MD_WAIT cycle aborts the sequence at once.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    #1;
    check("mid_reset_pre", 5'b10011);
    Reset_n = 1'b0;
    #1;
    check("mid_reset_abort", 5'b00000);
    tick();
    Reset_n = 1'b1;
    #3;
    check("mid_reset_release", 5'b00000);
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if ({StallCycles, LoadUseEvents, RedirectCount} !== 96'd0) begin
      bad++;
      $display("FAIL perf_after_mid_reset: got %h %h %h expected 0", StallCycles, LoadUseEvents, RedirectCount);
    end
`endif
    tick();
    #3;
    check("mid_reset_stays_run", 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
